// File: rtl/orb_frame_wr_arb.sv
// Write-side controller for the double-buffered orbit frame memory.
// Two word sources (fast, slow) are arbitrated into the bank that the
// serializer is not reading. Every write is a 3-cycle IDLE/WRITE/RECOVER
// sequence. The block counts writes per bank period and flags requests
// that are still waiting when the bank switches.
module orb_frame_wr_arb #(
  parameter int AW       = 11,
  parameter int DW       = 12,
  parameter int MAX_FAST = 4
) (
  input  logic          iClkOrb,
  input  logic          reset,
  input  logic          iSwitch,
  input  logic          iFastReq,
  input  logic [AW-1:0] iFastAddr,
  input  logic [DW-1:0] iFastData,
  output logic          oFastAck,
  input  logic          iSlowReq,
  input  logic [AW-1:0] iSlowAddr,
  input  logic [DW-1:0] iSlowData,
  output logic          oSlowAck,
  output logic [AW:0]   oWrAddr,
  output logic [DW-1:0] oWrData,
  output logic          oWrEn,
  output logic          oBusy,
  output logic [AW:0]   oWrCount,
  output logic [AW:0]   oLastCount,
  output logic          oOverrun,
  input  logic          iClrErr
);

  localparam int SW = $clog2(MAX_FAST + 1);
  localparam logic [AW:0] CNT_MAX = {(AW+1){1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RECOVER = 2'd2
  } stateT;

  // Saturating increment of a write counter.
  function automatic logic [AW:0] satInc(input logic [AW:0] v);
    logic [AW:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + {{AW{1'b0}}, 1'b1};
    end
    return r;
  endfunction

  stateT         state;
  stateT         stateNxt;
  logic          swD;
  logic          wbank;
  logic          switchEdge;
  logic [SW-1:0] streak;
  logic [SW-1:0] streakNxt;
  logic          slowWins;
  logic          fastGrant;
  logic          slowGrant;
  logic          missed;
  // A granted write that has not yet been added to oWrCount.
  logic          pendCnt;
  logic          pendCntNxt;
  logic          addNow;
  logic          wrEnNxt;
  logic          fastAckNxt;
  logic          slowAckNxt;
  logic [AW:0]   wrAddrNxt;
  logic [DW-1:0] wrDataNxt;
  logic [AW:0]   cntNxt;
  logic [AW:0]   lastNxt;
  logic          ovNxt;
  logic          busyNxt;

  // The serializer reads bank swD, so writes go to the other one.
  assign wbank      = ~swD;
  assign switchEdge = (iSwitch != swD);
  assign slowWins   = iSlowReq && (!iFastReq || (streak == SW'(MAX_FAST)));

  // FSM state register
  always_ff @(posedge iClkOrb or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  // Next state, arbitration, counters and next output values
  always_comb begin
    stateNxt   = state;
    fastGrant  = 1'b0;
    slowGrant  = 1'b0;
    wrEnNxt    = 1'b0;
    fastAckNxt = 1'b0;
    slowAckNxt = 1'b0;
    wrAddrNxt  = oWrAddr;
    wrDataNxt  = oWrData;
    pendCntNxt = pendCnt;
    streakNxt  = streak;
    addNow     = 1'b0;
    missed     = 1'b0;
    cntNxt     = oWrCount;
    lastNxt    = oLastCount;
    ovNxt      = oOverrun;
    busyNxt    = 1'b0;

    case (state)
      IDLE: begin
        if (iFastReq || iSlowReq) begin
          stateNxt = WRITE;
          wrEnNxt  = 1'b1;
          // A grant on a switch edge belongs to the period that is ending,
          // so it is counted there immediately rather than in WRITE.
          pendCntNxt = ~switchEdge;
          addNow     = switchEdge;
          if (slowWins) begin
            slowGrant  = 1'b1;
            slowAckNxt = 1'b1;
            wrAddrNxt  = {wbank, iSlowAddr};
            wrDataNxt  = iSlowData;
            streakNxt  = {SW{1'b0}};
          end else begin
            fastGrant  = 1'b1;
            fastAckNxt = 1'b1;
            wrAddrNxt  = {wbank, iFastAddr};
            wrDataNxt  = iFastData;
            if (!iSlowReq) begin
              streakNxt = {SW{1'b0}};
            end else if (streak == SW'(MAX_FAST)) begin
              streakNxt = streak;
            end else begin
              streakNxt = streak + SW'(1);
            end
          end
        end else begin
          stateNxt = IDLE;
        end
      end
      WRITE: begin
        stateNxt   = RECOVER;
        addNow     = pendCnt;
        pendCntNxt = 1'b0;
      end
      RECOVER: begin
        stateNxt = IDLE;
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase

    missed = (iFastReq && !fastGrant) || (iSlowReq && !slowGrant);

    if (switchEdge) begin
      lastNxt = addNow ? satInc(oWrCount) : oWrCount;
      cntNxt  = {(AW+1){1'b0}};
    end else if (addNow) begin
      cntNxt = satInc(oWrCount);
    end else begin
      cntNxt = oWrCount;
    end

    // Setting takes priority over a simultaneous clear.
    if (switchEdge && missed) begin
      ovNxt = 1'b1;
    end else if (iClrErr) begin
      ovNxt = 1'b0;
    end else begin
      ovNxt = oOverrun;
    end

    busyNxt = (stateNxt != IDLE);
  end

  // Registered outputs, bank tracking and arbitration history
  always_ff @(posedge iClkOrb or negedge reset) begin
    if (!reset) begin
      swD        <= 1'b0;
      streak     <= {SW{1'b0}};
      pendCnt    <= 1'b0;
      oWrEn      <= 1'b0;
      oFastAck   <= 1'b0;
      oSlowAck   <= 1'b0;
      oWrAddr    <= {(AW+1){1'b0}};
      oWrData    <= {DW{1'b0}};
      oWrCount   <= {(AW+1){1'b0}};
      oLastCount <= {(AW+1){1'b0}};
      oOverrun   <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      swD        <= iSwitch;
      streak     <= streakNxt;
      pendCnt    <= pendCntNxt;
      oWrEn      <= wrEnNxt;
      oFastAck   <= fastAckNxt;
      oSlowAck   <= slowAckNxt;
      oWrAddr    <= wrAddrNxt;
      oWrData    <= wrDataNxt;
      oWrCount   <= cntNxt;
      oLastCount <= lastNxt;
      oOverrun   <= ovNxt;
      oBusy      <= busyNxt;
    end
  end

endmodule

// File: tb/tb_orb_frame_wr_arb.sv
// Directed bench for orb_frame_wr_arb. A transaction-level model
// (grant cooldown, per-period grant totals) predicts every output
// after every clock edge. Literal checks pin the model at key points.
module tb_orb_frame_wr_arb;
  localparam int AW = 11;
  localparam int DW = 12;
  localparam int MAX_FAST = 4;

  logic          iClkOrb = 1'b0;
  logic          reset;
  logic          iSwitch;
  logic          iFastReq;
  logic [AW-1:0] iFastAddr;
  logic [DW-1:0] iFastData;
  logic          oFastAck;
  logic          iSlowReq;
  logic [AW-1:0] iSlowAddr;
  logic [DW-1:0] iSlowData;
  logic          oSlowAck;
  logic [AW:0]   oWrAddr;
  logic [DW-1:0] oWrData;
  logic          oWrEn;
  logic          oBusy;
  logic [AW:0]   oWrCount;
  logic [AW:0]   oLastCount;
  logic          oOverrun;
  logic          iClrErr;

  orb_frame_wr_arb #(.AW(AW), .DW(DW), .MAX_FAST(MAX_FAST)) dut (
    .iClkOrb(iClkOrb), .reset(reset), .iSwitch(iSwitch),
    .iFastReq(iFastReq), .iFastAddr(iFastAddr), .iFastData(iFastData), .oFastAck(oFastAck),
    .iSlowReq(iSlowReq), .iSlowAddr(iSlowAddr), .iSlowData(iSlowData), .oSlowAck(oSlowAck),
    .oWrAddr(oWrAddr), .oWrData(oWrData), .oWrEn(oWrEn), .oBusy(oBusy),
    .oWrCount(oWrCount), .oLastCount(oLastCount), .oOverrun(oOverrun), .iClrErr(iClrErr)
  );

  always #5 iClkOrb = ~iClkOrb;

  int nChecks = 0;
  int nFail = 0;

  // Model state
  int          mBusyLeft;   // cycles before the next grant may happen
  bit          mSwD;        // bank the serializer is reading
  int          mStreak;
  int          mGranted;    // writes granted in the current bank period
  bit          mUncounted;  // one of those is still in flight
  int          mLast;
  bit          mOv, mWrEn, mFA, mSA;
  logic [AW:0] mAddr;
  logic [DW-1:0] mData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mBusyLeft = 0; mSwD = 1'b0; mStreak = 0; mGranted = 0; mUncounted = 1'b0;
    mLast = 0; mOv = 1'b0; mWrEn = 1'b0; mFA = 1'b0; mSA = 1'b0;
    mAddr = '0; mData = '0;
  endtask

  task automatic compareAll();
    int expCnt;
    expCnt = mGranted - (mUncounted ? 1 : 0);
    if (expCnt > 4095) expCnt = 4095;
    chk("wrEn", 32'(oWrEn), 32'(mWrEn));
    chk("fastAck", 32'(oFastAck), 32'(mFA));
    chk("slowAck", 32'(oSlowAck), 32'(mSA));
    chk("wrAddr", 32'(oWrAddr), 32'(mAddr));
    chk("wrData", 32'(oWrData), 32'(mData));
    chk("busy", 32'(oBusy), 32'(mBusyLeft != 0));
    chk("wrCount", 32'(oWrCount), 32'(expCnt));
    chk("lastCount", 32'(oLastCount), 32'(mLast));
    chk("overrun", 32'(oOverrun), 32'(mOv));
  endtask

  // Advance the model with the inputs present before the edge, clock once, compare.
  task automatic cycle();
    bit sw, fg, sg;
    sw = (iSwitch != mSwD);
    fg = 1'b0; sg = 1'b0;
    if (mBusyLeft == 0 && (iFastReq || iSlowReq)) begin
      sg = iSlowReq && (!iFastReq || mStreak == MAX_FAST);
      fg = !sg;
    end
    mWrEn = fg | sg; mFA = fg; mSA = sg;
    if (fg) begin
      mAddr = {~mSwD, iFastAddr}; mData = iFastData;
      mStreak = iSlowReq ? ((mStreak < MAX_FAST) ? mStreak + 1 : MAX_FAST) : 0;
    end
    if (sg) begin
      mAddr = {~mSwD, iSlowAddr}; mData = iSlowData; mStreak = 0;
    end
    if (mBusyLeft == 2) mUncounted = 1'b0;
    if (fg | sg) begin mGranted++; mUncounted = 1'b1; end
    if (sw) begin
      mLast = (mGranted > 4095) ? 4095 : mGranted;
      mGranted = 0; mUncounted = 1'b0;
    end
    if (sw && ((iFastReq && !fg) || (iSlowReq && !sg))) mOv = 1'b1;
    else if (iClrErr) mOv = 1'b0;
    if (fg | sg) mBusyLeft = 2;
    else if (mBusyLeft > 0) mBusyLeft--;
    mSwD = iSwitch;
    @(posedge iClkOrb);
    #1;
    compareAll();
  endtask

  task automatic doWrite(input bit slow, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (slow) begin iSlowReq = 1'b1; iSlowAddr = a; iSlowData = d; end
    else begin iFastReq = 1'b1; iFastAddr = a; iFastData = d; end
    cycle();
    iSlowReq = 1'b0; iFastReq = 1'b0;
    cycle();
    cycle();
  endtask

  logic [9:0] order;
  int nG, prevI;

  initial begin
    reset = 1'b0; iSwitch = 1'b0; iFastReq = 1'b0; iSlowReq = 1'b0; iClrErr = 1'b0;
    iFastAddr = '0; iFastData = '0; iSlowAddr = '0; iSlowData = '0;
    modelReset();
    repeat (2) @(posedge iClkOrb);
    #1;
    compareAll();
    chk("rst_wrEn", 32'(oWrEn), 32'd0);
    chk("rst_count", 32'(oWrCount), 32'd0);
    reset = 1'b1;
    cycle();

    // Single fast write into bank 1
    iFastReq = 1'b1; iFastAddr = 11'h010; iFastData = 12'hABC;
    cycle();
    chk("t1_wrEn", 32'(oWrEn), 32'd1);
    chk("t1_addr", 32'(oWrAddr), 32'h810);
    chk("t1_data", 32'(oWrData), 32'hABC);
    chk("t1_fack", 32'(oFastAck), 32'd1);
    iFastReq = 1'b0;
    cycle();
    chk("t1_count", 32'(oWrCount), 32'd1);
    chk("t1_wrEn_off", 32'(oWrEn), 32'd0);
    cycle();

    // Both channels requesting continuously
    iFastReq = 1'b1; iFastAddr = 11'h100; iFastData = 12'h111;
    iSlowReq = 1'b1; iSlowAddr = 11'h200; iSlowData = 12'h222;
    order = '0; nG = 0; prevI = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (oWrEn) begin
        order = {order[8:0], oSlowAck};
        if (nG > 0) chk("t2_gap", 32'(i - prevI), 32'd3);
        prevI = i;
        nG++;
      end
    end
    chk("t2_grants", 32'(nG), 32'd10);
    chk("t2_order", 32'(order), 32'b0000100001);
    iFastReq = 1'b0; iSlowReq = 1'b0;

    // Bank switch while idle, then a slow-only write into bank 0
    iSwitch = 1'b1;
    cycle();
    chk("t3_last", 32'(oLastCount), 32'd11);
    chk("t3_count", 32'(oWrCount), 32'd0);
    iSlowReq = 1'b1; iSlowAddr = 11'h7FF; iSlowData = 12'h123;
    cycle();
    chk("t3_addr", 32'(oWrAddr), 32'h7FF);
    chk("t3_sack", 32'(oSlowAck), 32'd1);
    chk("t3_fack", 32'(oFastAck), 32'd0);
    iSlowReq = 1'b0;
    cycle();
    cycle();

    // Five writes in the period, then switch while idle
    for (int i = 0; i < 4; i++) doWrite(1'b0, 11'(i), 12'(i + 5));
    chk("t4_count5", 32'(oWrCount), 32'd5);
    iSwitch = 1'b0;
    cycle();
    chk("t4_last", 32'(oLastCount), 32'd5);
    chk("t4_count0", 32'(oWrCount), 32'd0);
    iFastReq = 1'b1; iFastAddr = 11'h055; iFastData = 12'h0F0;
    cycle();
    chk("t4_addr", 32'(oWrAddr), 32'h855);
    iFastReq = 1'b0;
    cycle();
    cycle();

    // Switch during WRITE, then a request pending at a switch in RECOVER
    iFastReq = 1'b1; iFastAddr = 11'h0AA; iFastData = 12'h5A5;
    cycle();
    chk("t5_addr", 32'(oWrAddr), 32'h8AA);
    iFastReq = 1'b0; iSwitch = 1'b1;
    cycle();
    chk("t5_last", 32'(oLastCount), 32'd2);
    chk("t5_count", 32'(oWrCount), 32'd0);
    iFastReq = 1'b1; iFastAddr = 11'h033; iSwitch = 1'b0;
    cycle();
    chk("t5_ovset", 32'(oOverrun), 32'd1);
    cycle();
    chk("t5_served", 32'(oFastAck), 32'd1);
    iFastReq = 1'b0;
    cycle();
    cycle();
    chk("t5_ovsticky", 32'(oOverrun), 32'd1);
    iClrErr = 1'b1;
    cycle();
    chk("t5_ovclr", 32'(oOverrun), 32'd0);
    iClrErr = 1'b0;

    // Clear coincident with a new overrun: set wins
    iFastReq = 1'b1;
    cycle();
    iFastReq = 1'b0;
    cycle();
    iFastReq = 1'b1; iSwitch = 1'b1; iClrErr = 1'b1;
    cycle();
    chk("t6_setwins", 32'(oOverrun), 32'd1);
    iClrErr = 1'b0;
    cycle();
    iFastReq = 1'b0;
    cycle();

    // Reset asserted during WRITE
    cycle();
    iFastReq = 1'b1; iFastAddr = 11'h3C3; iFastData = 12'h777;
    cycle();
    reset = 1'b0;
    modelReset();
    #1;
    compareAll();
    chk("t7_wrEn", 32'(oWrEn), 32'd0);
    chk("t7_fack", 32'(oFastAck), 32'd0);
    chk("t7_ov", 32'(oOverrun), 32'd0);
    @(posedge iClkOrb);
    #1;
    reset = 1'b1; iFastReq = 1'b0;
    cycle();
    cycle();
    chk("t7_idle", 32'(oBusy), 32'd0);
    doWrite(1'b0, 11'h001, 12'h002);

    // Counter saturation
    iFastReq = 1'b1; iFastAddr = 11'h444; iFastData = 12'h999;
    repeat (4097 * 3) cycle();
    iFastReq = 1'b0;
    cycle();
    chk("t8_sat", 32'(oWrCount), 32'd4095);
    iSwitch = ~iSwitch;
    cycle();
    chk("t8_last", 32'(oLastCount), 32'd4095);
    chk("t8_zero", 32'(oWrCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
